// File: rtl/core_pkg.sv
// Shared types and encodings for the core's memory-port arbitration logic.
package core_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MASK_W   = 4;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_WAIT_INSTR = 2'd1,
    ARB_WAIT_DATA  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_INSTR = 2'd1,
    SEL_DATA  = 2'd2
  } arb_sel_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, LSU and memory-side handshake signals of the shared memory port.
interface mem_port_arbiter_if;
  import core_pkg::*;

  logic              instr_req;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_gnt;
  logic              instr_rvalid;
  logic [DATA_W-1:0] instr_rdata;

  logic              data_req;
  logic [ADDR_W-1:0] data_addr;
  logic              data_we;
  logic [MASK_W-1:0] data_wmask;
  logic [DATA_W-1:0] data_wdata;
  logic              data_lock;
  logic              data_gnt;
  logic              data_rvalid;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [MASK_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              stray_rvalid;

  // Arbiter side
  modport master (
    input  instr_req, instr_addr,
    output instr_gnt, instr_rvalid, instr_rdata,
    input  data_req, data_addr, data_we, data_wmask, data_wdata, data_lock,
    output data_gnt, data_rvalid, data_rdata,
    output mem_req, mem_addr, mem_we, mem_wmask, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output stray_rvalid
  );

  // Core and memory side
  modport slave (
    output instr_req, instr_addr,
    input  instr_gnt, instr_rvalid, instr_rdata,
    output data_req, data_addr, data_we, data_wmask, data_wdata, data_lock,
    input  data_gnt, data_rvalid, data_rdata,
    input  mem_req, mem_addr, mem_we, mem_wmask, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  stray_rvalid
  );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of data grants taken while fetch was left waiting.
module arb_starve_counter
  import core_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  logic [STARVE_W-1:0] count_q;

  assign limit_hit = (count_q == STARVE_W'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && !limit_hit) begin
      count_q <= count_q + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and LSU, one transaction in flight,
// with data priority, misaligned-pair locking and fetch anti-starvation.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  mem_port_arbiter_if.master  bus
);

  arb_state_e state_q, state_d;
  arb_sel_e   sel;
  mem_cmd_t   cmd;
  logic       lock_q;
  logic       starve_hit;
  logic       instr_gnt_c, data_gnt_c;
  logic       instr_rvalid_c, data_rvalid_c, stray_c;

  // Requester selection; only meaningful in IDLE and blanked during reset
  always_comb begin
    sel = SEL_NONE;
    if (reset_i && state_q == ARB_IDLE) begin
      if (lock_q)                             sel = bus.data_req ? SEL_DATA : SEL_NONE;
      else if (bus.instr_req && starve_hit)   sel = SEL_INSTR;
      else if (bus.data_req)                  sel = SEL_DATA;
      else if (bus.instr_req)                 sel = SEL_INSTR;
    end
  end

  always_comb begin
    cmd = '0;
    case (sel)
      SEL_INSTR: cmd.addr = bus.instr_addr;
      SEL_DATA:  cmd = '{addr: bus.data_addr, we: bus.data_we,
                         wmask: bus.data_wmask, wdata: bus.data_wdata};
      default:   cmd = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    instr_gnt_c    = 1'b0;
    data_gnt_c     = 1'b0;
    instr_rvalid_c = 1'b0;
    data_rvalid_c  = 1'b0;
    stray_c        = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // A response with nothing outstanding is dropped, even alongside a grant
        stray_c = reset_i && bus.mem_rvalid;
        if (bus.mem_gnt && sel == SEL_DATA) begin
          data_gnt_c = 1'b1;
          state_d    = ARB_WAIT_DATA;
        end else if (bus.mem_gnt && sel == SEL_INSTR) begin
          instr_gnt_c = 1'b1;
          state_d     = ARB_WAIT_INSTR;
        end
      end
      ARB_WAIT_INSTR: begin
        if (bus.mem_rvalid) begin
          instr_rvalid_c = 1'b1;
          state_d        = ARB_IDLE;
        end
      end
      ARB_WAIT_DATA: begin
        if (bus.mem_rvalid) begin
          data_rvalid_c = 1'b1;
          state_d       = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Beat 1 of a misaligned pair reserves the port; beat 2 releases it
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)        lock_q <= 1'b0;
    else if (data_gnt_c) lock_q <= bus.data_lock;
  end

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk       (clk_i),
    .rst_n     (reset_i),
    .inc       (data_gnt_c),
    .clr       (!bus.instr_req || instr_gnt_c),
    .limit_hit (starve_hit)
  );

  assign bus.mem_req      = (sel != SEL_NONE);
  assign bus.mem_addr     = cmd.addr;
  assign bus.mem_we       = cmd.we;
  assign bus.mem_wmask    = cmd.wmask;
  assign bus.mem_wdata    = cmd.wdata;
  assign bus.instr_gnt    = instr_gnt_c;
  assign bus.data_gnt     = data_gnt_c;
  assign bus.instr_rvalid = instr_rvalid_c;
  assign bus.data_rvalid  = data_rvalid_c;
  assign bus.instr_rdata  = instr_rvalid_c ? bus.mem_rdata : '0;
  assign bus.data_rdata   = data_rvalid_c  ? bus.mem_rdata : '0;
  assign bus.stray_rvalid = stray_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a response scoreboard.
module tb_mem_port_arbiter;
  import core_pkg::*;

  localparam int unsigned LIMIT = 4;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [65:0] mon_got, mon_exp;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Every response delivered to a requester is matched against the scoreboard
  always @(negedge clk) begin
    if (bus.instr_rvalid || bus.data_rvalid) begin
      total++;
      mon_got = {bus.instr_rvalid, bus.data_rvalid, bus.instr_rdata, bus.data_rdata};
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_rvalid got=%h expected no response", mon_got);
      end else begin
        mon_e   = sb.pop_front();
        mon_exp = {!mon_e.is_data, mon_e.is_data,
                   mon_e.is_data ? 32'h0 : mon_e.rdata,
                   mon_e.is_data ? mon_e.rdata : 32'h0};
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL sb_response got=%h expected=%h", mon_got, mon_exp);
        end
      end
    end
  end

  function automatic logic [138:0] out_vec();
    return {bus.instr_gnt, bus.instr_rvalid, bus.instr_rdata,
            bus.data_gnt, bus.data_rvalid, bus.data_rdata,
            bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wmask, bus.mem_wdata,
            bus.stray_rvalid};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.instr_req  = 1'b0;
    bus.instr_addr = '0;
    bus.data_req   = 1'b0;
    bus.data_addr  = '0;
    bus.data_we    = 1'b0;
    bus.data_wmask = '0;
    bus.data_wdata = '0;
    bus.data_lock  = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic expect_rsp(input bit is_data, input logic [31:0] rd);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = rd;
    sb.push_back(e);
  endtask

  task automatic do_grant(output logic ig, output logic dg);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    ig = bus.instr_gnt;
    dg = bus.data_gnt;
    cyc();
    bus.mem_gnt = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rd);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rd;
    @(negedge clk);
    cyc();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.instr_req  = 1'b1;  bus.instr_addr = 32'h44;
    bus.data_req   = 1'b1;  bus.data_addr  = 32'h88;
    bus.data_we    = 1'b1;  bus.data_wmask = 4'hF;  bus.data_wdata = 32'hFFFF_FFFF;
    bus.mem_gnt    = 1'b1;  bus.mem_rvalid = 1'b1;  bus.mem_rdata  = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    #2;
    total++;
    if (out_vec() !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h expected=0", out_vec());
    end
    cyc(); cyc();
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (out_vec() !== '0) begin
      bad++; $display("FAIL post_reset_idle got=%h expected=0", out_vec());
    end
    cyc();
  endtask

  task automatic test_fetch_only();
    logic ig, dg;
    bus.instr_req = 1'b1; bus.instr_addr = 32'h100;
    @(negedge clk);
    total++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wmask, bus.mem_wdata, bus.instr_gnt}
        !== {1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 1'b0}) begin
      bad++; $display("FAIL fetch_mux got req=%b addr=%h we=%b mask=%h wdata=%h gnt=%b expected 1 100 0 0 0 0",
                      bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wmask, bus.mem_wdata, bus.instr_gnt);
    end
    cyc();
    expect_rsp(1'b0, 32'hDEAD_BEEF);
    do_grant(ig, dg);
    total++;
    if ({ig, dg} !== 2'b10) begin
      bad++; $display("FAIL fetch_grant got ig=%b dg=%b expected 1 0", ig, dg);
    end
    bus.instr_req = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.mem_req, bus.instr_rvalid, bus.data_gnt, bus.instr_gnt} !== 4'b0) begin
      bad++; $display("FAIL fetch_wait got req=%b rv=%b dg=%b ig=%b expected 0", bus.mem_req,
                      bus.instr_rvalid, bus.data_gnt, bus.instr_gnt);
    end
    cyc();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if ({bus.instr_rvalid, bus.instr_rdata, bus.data_gnt, bus.data_rvalid, bus.data_rdata}
        !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0}) begin
      bad++; $display("FAIL fetch_response got irv=%b ird=%h dg=%b drv=%b drd=%h expected 1 deadbeef 0 0 0",
                      bus.instr_rvalid, bus.instr_rdata, bus.data_gnt, bus.data_rvalid, bus.data_rdata);
    end
    cyc();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic test_data_priority();
    logic ig, dg;
    bus.instr_req = 1'b1; bus.instr_addr = 32'h300;
    bus.data_req  = 1'b1; bus.data_addr  = 32'h200; bus.data_we = 1'b1;
    bus.data_wmask = 4'b1100; bus.data_wdata = 32'h1234_0000; bus.data_lock = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wmask, bus.mem_wdata}
        !== {1'b1, 32'h200, 1'b1, 4'b1100, 32'h1234_0000}) begin
      bad++; $display("FAIL data_mux got req=%b addr=%h we=%b mask=%b wdata=%h expected 1 200 1 1100 12340000",
                      bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wmask, bus.mem_wdata);
    end
    cyc();
    expect_rsp(1'b1, 32'h0000_00AC);
    do_grant(ig, dg);
    total++;
    if ({ig, dg} !== 2'b01) begin
      bad++; $display("FAIL data_priority got ig=%b dg=%b expected 0 1", ig, dg);
    end
    bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_wmask = '0; bus.data_wdata = '0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_00AC; bus.mem_gnt = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.instr_gnt, bus.mem_req} !== 2'b00) begin
      bad++; $display("FAIL no_fetch_in_wait got ig=%b req=%b expected 0 0", bus.instr_gnt, bus.mem_req);
    end
    cyc();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_gnt = 1'b0;
    expect_rsp(1'b0, 32'h0000_0033);
    do_grant(ig, dg);
    total++;
    if ({ig, dg} !== 2'b10) begin
      bad++; $display("FAIL fetch_after_data got ig=%b dg=%b expected 1 0", ig, dg);
    end
    bus.instr_req = 1'b0;
    respond(32'h0000_0033);
  endtask

  task automatic test_lock();
    logic ig, dg;
    bus.instr_req = 1'b1; bus.instr_addr = 32'h400;
    bus.data_req  = 1'b1; bus.data_addr  = 32'h200; bus.data_lock = 1'b1;
    expect_rsp(1'b1, 32'h0302_0100);
    do_grant(ig, dg);
    total++;
    if ({ig, dg} !== 2'b01) begin
      bad++; $display("FAIL lock_beat1 got ig=%b dg=%b expected 0 1", ig, dg);
    end
    bus.data_req = 1'b0; bus.data_lock = 1'b0;
    respond(32'h0302_0100);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.mem_req, bus.instr_gnt} !== 2'b00) begin
      bad++; $display("FAIL lock_blocks_fetch got req=%b ig=%b expected 0 0", bus.mem_req, bus.instr_gnt);
    end
    cyc();
    bus.mem_gnt = 1'b0;
    bus.data_req = 1'b1; bus.data_addr = 32'h204; bus.data_lock = 1'b0;
    expect_rsp(1'b1, 32'h0706_0504);
    do_grant(ig, dg);
    total++;
    if ({ig, dg} !== 2'b01) begin
      bad++; $display("FAIL lock_beat2 got ig=%b dg=%b expected 0 1", ig, dg);
    end
    bus.data_req = 1'b0;
    respond(32'h0706_0504);
    expect_rsp(1'b0, 32'h0BAD_0001);
    do_grant(ig, dg);
    total++;
    if ({ig, dg} !== 2'b10) begin
      bad++; $display("FAIL lock_released got ig=%b dg=%b expected 1 0", ig, dg);
    end
    bus.instr_req = 1'b0;
    respond(32'h0BAD_0001);
  endtask

  task automatic test_starvation();
    logic ig, dg;
    bit   want_data;
    bus.instr_req = 1'b1; bus.instr_addr = 32'h500;
    bus.data_req  = 1'b1; bus.data_addr  = 32'h600; bus.data_we = 1'b1;
    bus.data_wmask = 4'hF; bus.data_wdata = 32'hCAFE_0000; bus.data_lock = 1'b0;
    for (int i = 0; i < 6; i++) begin
      want_data = (i != int'(LIMIT));
      expect_rsp(want_data, 32'h5000_0000 + 32'(i));
      do_grant(ig, dg);
      total++;
      if ({ig, dg} !== (want_data ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL starve_grant_%0d got ig=%b dg=%b expected data=%0b", i, ig, dg, want_data);
      end
      respond(32'h5000_0000 + 32'(i));
    end
    idle_inputs();
  endtask

  task automatic test_stray();
    idle_inputs();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    total++;
    if ({bus.stray_rvalid, bus.instr_rvalid, bus.data_rvalid, bus.instr_rdata, bus.data_rdata}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      bad++; $display("FAIL stray_pulse got stray=%b irv=%b drv=%b ird=%h drd=%h expected 1 0 0 0 0",
                      bus.stray_rvalid, bus.instr_rvalid, bus.data_rvalid, bus.instr_rdata, bus.data_rdata);
    end
    cyc();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    @(negedge clk);
    total++;
    if (bus.stray_rvalid !== 1'b0) begin
      bad++; $display("FAIL stray_one_cycle got stray=%b expected 0", bus.stray_rvalid);
    end
    cyc();
    bus.instr_req = 1'b1; bus.instr_addr = 32'h700;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0077; bus.mem_gnt = 1'b1;
    expect_rsp(1'b0, 32'h1212_1212);
    @(negedge clk);
    total++;
    if ({bus.instr_gnt, bus.stray_rvalid, bus.instr_rvalid} !== 3'b110) begin
      bad++; $display("FAIL gnt_with_stray got ig=%b stray=%b irv=%b expected 1 1 0",
                      bus.instr_gnt, bus.stray_rvalid, bus.instr_rvalid);
    end
    cyc();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.instr_req = 1'b0;
    respond(32'h1212_1212);
  endtask

  task automatic test_reset_mid();
    logic ig, dg;
    bus.instr_req = 1'b1; bus.instr_addr = 32'h800;
    bus.data_req  = 1'b1; bus.data_addr  = 32'h900; bus.data_lock = 1'b1; bus.data_we = 1'b0;
    do_grant(ig, dg);
    total++;
    if ({ig, dg} !== 2'b01) begin
      bad++; $display("FAIL midreset_setup got ig=%b dg=%b expected 0 1", ig, dg);
    end
    bus.data_req = 1'b0; bus.data_lock = 1'b0;
    #2;
    rst_n = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDDDD_0000;
    #1;
    total++;
    if (out_vec() !== '0) begin
      bad++; $display("FAIL midreset_outputs got=%h expected=0", out_vec());
    end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.stray_rvalid, bus.instr_rvalid, bus.data_rvalid, bus.mem_req, bus.mem_addr}
        !== {1'b1, 1'b0, 1'b0, 1'b1, 32'h800}) begin
      bad++; $display("FAIL midreset_late_rsp got stray=%b irv=%b drv=%b req=%b addr=%h expected 1 0 0 1 800",
                      bus.stray_rvalid, bus.instr_rvalid, bus.data_rvalid, bus.mem_req, bus.mem_addr);
    end
    cyc();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    expect_rsp(1'b0, 32'h0000_F00D);
    do_grant(ig, dg);
    total++;
    if ({ig, dg} !== 2'b10) begin
      bad++; $display("FAIL midreset_fetch got ig=%b dg=%b expected 1 0", ig, dg);
    end
    bus.instr_req = 1'b0;
    respond(32'h0000_F00D);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_data_priority();
    test_lock();
    test_starvation();
    test_stray();
    test_reset_mid();
    cyc();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_drained got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch and the load/store unit.
- Handles req/gnt/rvalid handshaking with one transaction outstanding at a time.
- Data has priority over fetch. A lock holds the port for both beats of a split misaligned access.
- A starvation counter guarantees fetch progress. Sits between the core (fetch stage, LSU outputs) and the memory/bus interface.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch is pending before fetch wins (1..15).

Ports:
- clk_i  in  1  core clock
- reset_i  in  1  asynchronous, active-low reset
- instr_req_i  in  1  fetch request, held until instr_gnt_o
- instr_addr_i  in  32  fetch word address
- instr_gnt_o  out  1  fetch address phase accepted
- instr_rvalid_o  out  1  fetch read data valid
- instr_rdata_o  out  32  fetch read data
- data_req_i  in  1  LSU request, held until data_gnt_o
- data_addr_i  in  32  LSU word-aligned address
- data_we_i  in  1  1 = store
- data_wmask_i  in  4  byte write mask
- data_wdata_i  in  32  store data, byte-lane aligned
- data_lock_i  in  1  high on the first beat of a two-beat misaligned access
- data_gnt_o  out  1  LSU address phase accepted
- data_rvalid_o  out  1  LSU load data valid, or store acknowledge
- data_rdata_o  out  32  LSU load data
- mem_req_o  out  1  memory request
- mem_addr_o  out  32  memory address
- mem_we_o  out  1  memory write enable
- mem_wmask_o  out  4  memory byte mask
- mem_wdata_o  out  32  memory write data
- mem_gnt_i  in  1  memory accepted address phase
- mem_rvalid_i  in  1  memory response valid, one per granted request, at least 1 cycle after grant
- mem_rdata_i  in  32  memory read data
- stray_rvalid_o  out  1  pulse: mem_rvalid_i arrived with no outstanding transaction

Behaviour:
- States: IDLE, WAIT_INSTR, WAIT_DATA.
- Registers:
  - lock_q: port reserved for data.
  - starve_q: 4-bit counter.
- Reset (reset_i low, asynchronous):
  - State IDLE; lock_q = 0; starve_q = 0.
  - All outputs forced 0 regardless of inputs.
- IDLE arbitration (combinational, same cycle):
  - lock_q = 1: data only. instr_req_i is ignored; mem_req_o = data_req_i.
  - else if instr_req_i and starve_q == STARVE_LIMIT: fetch selected.
  - else if data_req_i: data selected.
  - else if instr_req_i: fetch selected.
  - else mem_req_o = 0.
- Muxing: mem_addr/we/wmask/wdata come from the selected requester. For fetch: we = 0, wmask = 0, wdata = 0. With no requester selected, all mem_* outputs are 0.
- Grant: when mem_gnt_i is high with mem_req_o high, pulse the selected requester's gnt_o in the same cycle (combinational). Next state is WAIT_INSTR or WAIT_DATA.
- Without mem_gnt_i, the selection is re-evaluated each cycle.
  - Requesters must hold their request stable until granted.
  - Priority may change only if a new higher-priority request appears.
- WAIT_x:
  - mem_req_o = 0; all gnt_o = 0.
  - On mem_rvalid_i: pulse the owner's rvalid_o in the same cycle, with rdata_o = mem_rdata_i. Next state IDLE. New arbitration starts the following cycle, so minimum 2 cycles per access.
  - The non-owner's rdata_o is 0 at all times. The owner's rdata_o equals mem_rdata_i only when its rvalid_o is high, else 0.
- Lock:
  - On a data grant, lock_q <= data_lock_i.
  - A lock set on beat 1 is cleared by the beat-2 grant, which has data_lock_i = 0.
  - A fetch grant never changes lock_q.
- Starvation counter (on the clock edge):
  - Data grant while instr_req_i high: starve_q <= starve_q + 1, saturating at STARVE_LIMIT.
  - Fetch grant, or instr_req_i low: starve_q <= 0.
  - Lock overrides starvation: fetch waits until the locked pair completes even if starve_q == STARVE_LIMIT.
- Simultaneous events: mem_gnt_i and mem_rvalid_i both high in IDLE. The grant is processed normally; the rvalid is treated as stray.
- stray_rvalid_o = mem_rvalid_i while in IDLE. Use case: a late response after a mid-transaction reset. The stray data is discarded and never forwarded.
- Reset mid-operation: the outstanding transaction is abandoned with no gnt or rvalid to either requester. Lock and counter are cleared.

Decomposition:
- Shared package core_pkg gets:
  - State encoding constants ARB_IDLE = 2'd0, ARB_WAIT_INSTR = 2'd1, ARB_WAIT_DATA = 2'd2.
  - Requester select constants SEL_NONE, SEL_INSTR, SEL_DATA.
- One natural sub-module: arb_starve_counter. It is the saturating counter with inc/clr/limit-reached flag, parameterised by STARVE_LIMIT.
- FSM, lock and mux logic stay in the top module.

Test Plan:
- Fetch only: instr_req_i = 1, addr 0x100; mem_gnt_i on cycle 1, rvalid on cycle 3 with rdata 0xDEADBEEF -> instr_gnt_o pulses on cycle 1; instr_rvalid_o = 1 and instr_rdata_o = 0xDEADBEEF on cycle 3; data outputs stay 0.
- Simultaneous requests, starve_q = 0 (data_req_i, data_we_i = 1, addr 0x200, mask 4'b1100, wdata 0x12340000) -> data wins: mem_we_o = 1, mem_wmask_o = 4'b1100; fetch is granted only after data rvalid and one IDLE cycle.
- Locked misaligned load at 0x203: beat 1 addr 0x200 with data_lock_i = 1, then beat 2 addr 0x204 with lock = 0; instr_req_i high throughout -> no instr_gnt_o until beat-2 rvalid; lock_q clears on the beat-2 grant.
- Starvation with STARVE_LIMIT = 4: data_req_i and instr_req_i held continuously -> 4 data grants, then a fetch grant; starve_q returns to 0.
- Stray response: mem_rvalid_i pulse in IDLE with rdata 0xA5A5A5A5 -> stray_rvalid_o = 1 for 1 cycle; both rvalid_o = 0 and both rdata_o = 0.
- Reset mid-transaction: reset_i low while in WAIT_DATA with lock_q = 1 -> all outputs 0 immediately; after release, a fetch request is granted (lock cleared); the late mem_rvalid_i raises stray_rvalid_o.
